// File: rtl/trap_sequencer_pkg.sv
// Shared cause codes and state encoding for the machine-mode trap sequencer.
package trap_sequencer_pkg;

    localparam int IRQ_MEI = 11;
    localparam int IRQ_MSI = 3;
    localparam int IRQ_MTI = 7;

    localparam int EXC_INSTR_MISALIGN = 0;
    localparam int EXC_INSTR_FAULT    = 1;
    localparam int EXC_ILLEGAL_INSTR  = 2;
    localparam int EXC_BREAKPOINT     = 3;
    localparam int EXC_LOAD_MISALIGN  = 4;
    localparam int EXC_LOAD_FAULT     = 5;
    localparam int EXC_STORE_MISALIGN = 6;
    localparam int EXC_STORE_FAULT    = 7;
    localparam int EXC_ECALL_M        = 11;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        COMMIT   = 3'd2,
        RET      = 3'd3,
        REDIRECT = 3'd4
    } trap_seq_state_t;

endpackage

// File: rtl/trap_sequencer_if.sv
// Fetch redirect handshake between the trap sequencer (master) and fetch (slave).
interface trap_sequencer_if #(
    parameter int XLEN = 32
) ();
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (output redirect_valid, output redirect_pc, input redirect_ready);
    modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/trap_sequencer_irq_prio.sv
// Fixed-priority encoder over the masked pending interrupts: MEI > MSI > MTI.
module trap_irq_prio
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CODE_W = 4
) (
    input  logic [XLEN-1:0]   i_trap_ip,
    output logic              o_any,
    output logic [CODE_W-1:0] o_code
);
    // Only bits 11/3/7 matter; the rest are deliberately ignored.
    logic w_unused;
    assign w_unused = ^i_trap_ip;

    always_comb begin
        o_any  = 1'b0;
        o_code = '0;
        if (i_trap_ip[IRQ_MEI]) begin
            o_any  = 1'b1;
            o_code = CODE_W'(IRQ_MEI);
        end else if (i_trap_ip[IRQ_MSI]) begin
            o_any  = 1'b1;
            o_code = CODE_W'(IRQ_MSI);
        end else if (i_trap_ip[IRQ_MTI]) begin
            o_any  = 1'b1;
            o_code = CODE_W'(IRQ_MTI);
        end
    end
endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: accepts one request, drains the pipeline,
// strobes the trap unit and redirects fetch to the handler or mepc.
//
// state    | meaning
// IDLE     | waiting for interrupt / exception / mret
// DRAIN    | request latched, waiting for quiesce
// COMMIT   | one-cycle trap-entry strobe, capture handler address
// RET      | one-cycle trap-return strobe, capture mepc
// REDIRECT | redirect_valid held until fetch accepts
module trap_sequencer
    import trap_sequencer_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CODE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    i_trap_ip,
    input  logic               i_boundary,
    input  logic [XLEN-1:0]    i_next_pc,
    input  logic               i_exc_valid,
    input  logic [CODE_W-1:0]  i_exc_code,
    input  logic [XLEN-1:0]    i_exc_pc,
    input  logic [XLEN-1:0]    i_exc_tval,
    input  logic               i_mret,
    input  logic               i_quiesce,
    input  logic [XLEN-1:0]    i_trap_address,
    input  logic [XLEN-1:0]    i_mepc,
    output logic               o_trap_exeption,
    output logic               o_trap_return,
    output logic               o_trap_interrupt,
    output logic [XLEN-1:0]    o_trap_cause,
    output logic [XLEN-1:0]    o_mepc_bus,
    output logic [XLEN-1:0]    o_mtval_bus,
    output logic               o_hold,
    output logic               o_busy,
    trap_sequencer_if.master   redir
);
    trap_seq_state_t r_state;
    trap_seq_state_t w_next;

    logic              r_is_irq;
    logic              r_is_ret;
    logic [XLEN-1:0]   r_cause;
    logic [XLEN-1:0]   r_epc;
    logic [XLEN-1:0]   r_tval;
    logic [XLEN-1:0]   r_redirect_pc;

    logic              w_irq_any;
    logic [CODE_W-1:0] w_irq_code;
    logic              w_idle;
    logic              w_take_irq;
    logic              w_take_exc;
    logic              w_take_ret;
    logic              w_busy;

    trap_irq_prio #(.XLEN(XLEN), .CODE_W(CODE_W)) u_irq_prio (
        .i_trap_ip (i_trap_ip),
        .o_any     (w_irq_any),
        .o_code    (w_irq_code)
    );

    // Lower-priority requests in the same cycle are simply dropped.
    assign w_idle     = (r_state == IDLE);
    assign w_take_irq = w_idle && i_boundary && w_irq_any;
    assign w_take_exc = w_idle && !w_take_irq && i_exc_valid;
    assign w_take_ret = w_idle && !w_take_irq && !i_exc_valid && i_mret;
    assign w_busy     = !w_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next              = r_state;
        o_trap_exeption     = 1'b0;
        o_trap_return       = 1'b0;
        redir.redirect_valid = 1'b0;
        redir.redirect_pc   = '0;
        case (r_state)
            IDLE: begin
                if (w_take_irq || w_take_exc || w_take_ret) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (i_quiesce) begin
                    w_next = r_is_ret ? RET : COMMIT;
                end
            end
            COMMIT: begin
                o_trap_exeption = 1'b1;
                w_next          = REDIRECT;
            end
            RET: begin
                o_trap_return = 1'b1;
                w_next        = REDIRECT;
            end
            REDIRECT: begin
                redir.redirect_valid = 1'b1;
                redir.redirect_pc    = r_redirect_pc;
                if (redir.redirect_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_irq      <= 1'b0;
            r_is_ret      <= 1'b0;
            r_cause       <= '0;
            r_epc         <= '0;
            r_tval        <= '0;
            r_redirect_pc <= '0;
        end else begin
            if (w_take_irq) begin
                r_is_irq <= 1'b1;
                r_is_ret <= 1'b0;
                r_cause  <= {1'b1, {(XLEN-1-CODE_W){1'b0}}, w_irq_code};
                r_epc    <= i_next_pc;
                r_tval   <= '0;
            end else if (w_take_exc) begin
                r_is_irq <= 1'b0;
                r_is_ret <= 1'b0;
                r_cause  <= XLEN'(i_exc_code);
                r_epc    <= i_exc_pc;
                r_tval   <= i_exc_tval;
            end else if (w_take_ret) begin
                r_is_irq <= 1'b0;
                r_is_ret <= 1'b1;
                r_cause  <= '0;
                r_epc    <= '0;
                r_tval   <= '0;
            end
            if (r_state == COMMIT) begin
                r_redirect_pc <= i_trap_address;
            end else if (r_state == RET) begin
                r_redirect_pc <= i_mepc;
            end
        end
    end

    // Cause and interrupt flag stay put for the whole sequence so the
    // trap unit's vectored handler address cannot move under the redirect.
    assign o_trap_interrupt = w_busy && r_is_irq;
    assign o_trap_cause     = w_busy ? r_cause : '0;
    assign o_mepc_bus       = w_busy ? r_epc   : '0;
    assign o_mtval_bus      = w_busy ? r_tval  : '0;
    assign o_hold           = w_busy;
    assign o_busy           = w_busy;
endmodule

// File: tb/tb_trap_sequencer.sv
// Randomized scoreboard bench for trap_sequencer against a request-level model.
module tb_trap_sequencer;
    logic        clk;
    logic        rst;
    logic [31:0] i_trap_ip;
    logic        i_boundary;
    logic [31:0] i_next_pc;
    logic        i_exc_valid;
    logic [3:0]  i_exc_code;
    logic [31:0] i_exc_pc;
    logic [31:0] i_exc_tval;
    logic        i_mret;
    logic        i_quiesce;
    logic [31:0] i_trap_address;
    logic [31:0] i_mepc;
    logic        o_trap_exeption;
    logic        o_trap_return;
    logic        o_trap_interrupt;
    logic [31:0] o_trap_cause;
    logic [31:0] o_mepc_bus;
    logic [31:0] o_mtval_bus;
    logic        o_hold;
    logic        o_busy;

    trap_sequencer_if #(.XLEN(32)) rif ();

    trap_sequencer #(.XLEN(32), .CODE_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_trap_ip        (i_trap_ip),
        .i_boundary       (i_boundary),
        .i_next_pc        (i_next_pc),
        .i_exc_valid      (i_exc_valid),
        .i_exc_code       (i_exc_code),
        .i_exc_pc         (i_exc_pc),
        .i_exc_tval       (i_exc_tval),
        .i_mret           (i_mret),
        .i_quiesce        (i_quiesce),
        .i_trap_address   (i_trap_address),
        .i_mepc           (i_mepc),
        .o_trap_exeption  (o_trap_exeption),
        .o_trap_return    (o_trap_return),
        .o_trap_interrupt (o_trap_interrupt),
        .o_trap_cause     (o_trap_cause),
        .o_mepc_bus       (o_mepc_bus),
        .o_mtval_bus      (o_mtval_bus),
        .o_hold           (o_hold),
        .o_busy           (o_busy),
        .redir            (rif)
    );

    typedef struct {
        bit          is_ret;
        bit          irq;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic [31:0] rpc;
        int          scyc;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    bit   have_cur;
    bit   in_redir;
    bit   hs_pending;
    int   cyc;
    int   checks;
    int   errors;
    int   n_strobes;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Request-level reference: what the trap unit should see for a request bundle.
    function automatic bit ref_model(input logic [31:0] ip, input bit bnd, input logic [31:0] npc,
                                     input bit ev, input logic [3:0] code, input logic [31:0] epc,
                                     input logic [31:0] tval, input bit mr, input logic [31:0] taddr,
                                     input logic [31:0] mv, output exp_t e);
        e = '{default: 0};
        if (bnd && (ip[11] || ip[3] || ip[7])) begin
            e.irq   = 1;
            e.cause = 32'h8000_0000 + (ip[11] ? 32'd11 : (ip[3] ? 32'd3 : 32'd7));
            e.epc   = npc;
            e.tval  = 32'h0;
            e.rpc   = taddr;
            return 1;
        end
        if (ev) begin
            e.cause = {28'h0, code};
            e.epc   = epc;
            e.tval  = tval;
            e.rpc   = taddr;
            return 1;
        end
        if (mr) begin
            e.is_ret = 1;
            e.rpc    = mv;
            return 1;
        end
        return 0;
    endfunction

    // Monitor: pops the scoreboard on every strobe and follows the redirect.
    always @(negedge clk) begin
        if (rst) begin
            in_redir   <= 0;
            hs_pending <= 0;
            have_cur   <= 0;
        end else begin
            if (hs_pending) begin
                chk("hold_after_hs", {31'h0, o_hold}, 32'h0);
                chk("busy_after_hs", {31'h0, o_busy}, 32'h0);
                hs_pending = 0;
            end
            if (o_trap_exeption || o_trap_return) begin
                n_strobes++;
                chk("strobe_excl", {31'h0, o_trap_exeption & o_trap_return}, 32'h0);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: exc=%0b ret=%0b expected none (cycle %0d)",
                             o_trap_exeption, o_trap_return, cyc);
                end else begin
                    cur = expq.pop_front();
                    have_cur = 1;
                    chk("strobe_kind", {31'h0, o_trap_return}, {31'h0, cur.is_ret});
                    chk("strobe_cycle", cyc, cur.scyc);
                    if (!cur.is_ret) begin
                        chk("cause", o_trap_cause, cur.cause);
                        chk("mepc_bus", o_mepc_bus, cur.epc);
                        chk("mtval_bus", o_mtval_bus, cur.tval);
                        chk("irq_flag", {31'h0, o_trap_interrupt}, {31'h0, cur.irq});
                    end
                end
            end
            if (rif.redirect_valid) begin
                if (!have_cur) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_redirect: pc=%h expected no redirect", rif.redirect_pc);
                end else begin
                    if (!in_redir) begin
                        chk("redir_cycle", cyc, cur.scyc + 1);
                        in_redir = 1;
                    end
                    chk("redir_pc", rif.redirect_pc, cur.rpc);
                    chk("redir_irq_hold", {31'h0, o_trap_interrupt}, {31'h0, cur.irq});
                    if (!cur.is_ret) chk("redir_cause_hold", o_trap_cause, cur.cause);
                    chk("redir_hold", {31'h0, o_hold}, 32'h1);
                    if (rif.redirect_ready) begin
                        in_redir   = 0;
                        have_cur   = 0;
                        hs_pending = 1;
                    end
                end
            end
        end
    end

    task automatic run_seq(input logic [31:0] ip, input bit bnd, input logic [31:0] npc,
                           input bit ev, input logic [3:0] code, input logic [31:0] epc,
                           input logic [31:0] tval, input bit mr, input logic [31:0] taddr,
                           input logic [31:0] mv, input int qd, input int rd);
        exp_t e;
        bit   ok;
        bit   done;
        @(posedge clk); #1;
        i_trap_address = taddr;
        i_mepc         = mv;
        i_trap_ip      = ip;
        i_boundary     = bnd;
        i_next_pc      = npc;
        i_exc_valid    = ev;
        i_exc_code     = code;
        i_exc_pc       = epc;
        i_exc_tval     = tval;
        i_mret         = mr;
        i_quiesce      = (qd == 0);
        rif.redirect_ready = 1'b0;
        ok = ref_model(ip, bnd, npc, ev, code, epc, tval, mr, taddr, mv, e);
        if (ok) begin
            e.scyc = cyc + 2 + qd;
            expq.push_back(e);
        end
        @(posedge clk); #1;
        i_trap_ip   = 32'h0;
        i_boundary  = 1'b0;
        i_exc_valid = 1'b0;
        i_mret      = 1'b0;
        if (!ok) begin
            @(negedge clk);
            chk("idle_no_req", {31'h0, o_busy}, 32'h0);
            return;
        end
        for (int k = 0; k < qd; k++) begin
            @(negedge clk);
            chk("hold_drain", {31'h0, o_hold}, 32'h1);
            @(posedge clk); #1;
        end
        i_quiesce = 1'b1;
        repeat (2 + rd) begin
            @(negedge clk);
            chk("hold_seq", {31'h0, o_hold}, 32'h1);
            @(posedge clk); #1;
        end
        rif.redirect_ready = 1'b1;
        done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rif.redirect_valid) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL redirect_timeout: got no redirect_valid within 20 cycles, required one");
        end
        @(posedge clk); #1;
        rif.redirect_ready = 1'b0;
    endtask

    task automatic reset_in_drain();
        int strobes_before;
        strobes_before = n_strobes;
        @(posedge clk); #1;
        i_exc_valid = 1'b1;
        i_exc_code  = 4'd5;
        i_exc_pc    = 32'h0000_0440;
        i_exc_tval  = 32'h0000_BEEF;
        i_quiesce   = 1'b0;
        @(posedge clk); #1;
        i_exc_valid = 1'b0;
        @(negedge clk);
        chk("busy_in_drain", {31'h0, o_busy}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'h0, o_busy}, 32'h0);
        chk("rst_hold", {31'h0, o_hold}, 32'h0);
        chk("rst_cause", o_trap_cause, 32'h0);
        chk("rst_mepc", o_mepc_bus, 32'h0);
        chk("rst_mtval", o_mtval_bus, 32'h0);
        chk("rst_redir_valid", {31'h0, rif.redirect_valid}, 32'h0);
        i_quiesce = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rst_no_strobe", n_strobes, strobes_before);
        chk("rst_stay_idle", {31'h0, o_busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ip;
        logic [2:0]  sel;
        cyc = 0; checks = 0; errors = 0; n_strobes = 0;
        have_cur = 0; in_redir = 0; hs_pending = 0;
        rst = 1'b1;
        i_trap_ip = 0; i_boundary = 0; i_next_pc = 0; i_exc_valid = 0; i_exc_code = 0;
        i_exc_pc = 0; i_exc_tval = 0; i_mret = 0; i_quiesce = 0;
        i_trap_address = 0; i_mepc = 0; rif.redirect_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'h0, o_busy}, 32'h0);
        chk("reset_hold", {31'h0, o_hold}, 32'h0);
        chk("reset_strobes", {30'h0, o_trap_exeption, o_trap_return}, 32'h0);
        chk("reset_cause", o_trap_cause, 32'h0);
        chk("reset_redir", {31'h0, rif.redirect_valid}, 32'h0);

        // Directed scenarios
        run_seq(32'h0, 0, 32'h0, 1, 4'd2, 32'h100, 32'hDEAD, 0, 32'h80, 32'h0, 0, 0);
        run_seq(32'h0000_0880, 1, 32'h204, 0, 4'd0, 32'h0, 32'h0, 0, 32'h90, 32'h0, 0, 1);
        run_seq(32'h0000_0008, 1, 32'h208, 1, 4'd6, 32'h500, 32'h77, 0, 32'hA0, 32'h0, 1, 0);
        run_seq(32'h0, 0, 32'h0, 0, 4'd0, 32'h0, 32'h0, 1, 32'hB0, 32'h300, 5, 0);
        run_seq(32'h0, 0, 32'h0, 1, 4'd11, 32'h620, 32'h0, 1, 32'hC0, 32'h0, 0, 4);
        run_seq(32'h0000_0800, 0, 32'h700, 0, 4'd0, 32'h0, 32'h0, 0, 32'hD0, 32'h0, 0, 0);
        reset_in_drain();

        for (int n = 0; n < 60; n++) begin
            sel = 3'($urandom_range(0, 7));
            ip  = $urandom & ~32'h0000_0888;
            ip[11] = sel[2];
            ip[3]  = sel[1];
            ip[7]  = sel[0];
            run_seq(ip, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                    4'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)),
                    $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                    $urandom_range(0, 4), $urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", expq.size(), 32'h0);
        chk("no_open_redirect", {31'h0, have_cur}, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
